// File: rtl/usb_crc_pkg.sv
// Shared types and USB CRC constants for the serial CRC engine.
package usb_crc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    GEN   = 1'b1
  } crc_state_t;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/usb_crc_step.sv
// One-bit combinational CRC absorb: shift left, fold in POLY when the feedback bit is set.
module usb_crc_step
  import usb_crc_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_POLY)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q_next
);

  logic fb;

  assign fb     = bit_in ^ q[WIDTH-1];
  assign q_next = {q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/usb_crc_engine.sv
// Serial USB CRC engine: accumulates/checks a bit stream and shifts out the inverted CRC.
// Optional saturating error counter on port err_count when USB_CRC_ERR_CNT_EN is defined.
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(CRC16_POLY),
  parameter logic [WIDTH-1:0] RESIDUAL = WIDTH'(CRC16_RESIDUAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             gen_start,
  input  logic             tx_ready,
  input  logic             check,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_done,
  output logic             busy,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [WIDTH-1:0] crc_value
`ifdef USB_CRC_ERR_CNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  crc_state_t       state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt, q_abs;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tx_done_nxt;
  logic             crc_err_nxt;

  usb_crc_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .q      (q),
    .bit_in (bit_in),
    .q_next (q_abs)
  );

  assign crc_value = q;
  assign busy      = (state == GEN);
  assign tx_valid  = (state == GEN);
  assign tx_bit    = tx_valid & ~q[WIDTH-1];
  assign crc_ok    = (state == ACCUM) && (q == RESIDUAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      q       <= ONES;
      cnt     <= '0;
      tx_done <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      cnt     <= cnt_nxt;
      tx_done <= tx_done_nxt;
      crc_err <= crc_err_nxt;
    end
  end

  // clear overrides everything below it, including an in-flight generation
  always_comb begin
    state_nxt   = state;
    q_nxt       = q;
    cnt_nxt     = cnt;
    tx_done_nxt = 1'b0;
    crc_err_nxt = check & ~crc_ok;
    if (clear) begin
      state_nxt = ACCUM;
      q_nxt     = ONES;
    end else begin
      case (state)
        ACCUM: begin
          if (bit_valid) q_nxt = q_abs;
          if (gen_start) begin
            state_nxt = GEN;
            cnt_nxt   = CNT_LAST;
          end
        end
        GEN: begin
          if (tx_ready) begin
            q_nxt   = {q[WIDTH-2:0], 1'b1};
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == '0) begin
              q_nxt       = ONES;
              state_nxt   = ACCUM;
              tx_done_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

`ifdef USB_CRC_ERR_CNT_EN
  // Saturating count of failed checks; survives clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (crc_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine: CRC16 and CRC5 instances, hand-computed expectations.
module tb_usb_crc_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        clear16, bv16, bi16, gs16, rdy16, check16;
  logic        tx_valid16, tx_bit16, tx_done16, busy16, crc_ok16, crc_err16;
  logic [15:0] crc_value16;
  logic        clear5, bv5, bi5, gs5, rdy5, check5;
  logic        tx_valid5, tx_bit5, tx_done5, busy5, crc_ok5, crc_err5;
  logic [4:0]  crc_value5;
`ifdef USB_CRC_ERR_CNT_EN
  logic [7:0]  err_count16, err_count5;
`endif

  int n_vec = 0;
  int n_err = 0;

  usb_crc_engine #(.WIDTH(16), .POLY(16'h8005), .RESIDUAL(16'h800D)) u16 (
    .clk(clk), .rst(rst), .clear(clear16), .bit_valid(bv16), .bit_in(bi16),
    .gen_start(gs16), .tx_ready(rdy16), .check(check16),
    .tx_valid(tx_valid16), .tx_bit(tx_bit16), .tx_done(tx_done16), .busy(busy16),
    .crc_ok(crc_ok16), .crc_err(crc_err16), .crc_value(crc_value16)
`ifdef USB_CRC_ERR_CNT_EN
    , .err_count(err_count16)
`endif
  );

  usb_crc_engine #(.WIDTH(5), .POLY(5'h05), .RESIDUAL(5'h0C)) u5 (
    .clk(clk), .rst(rst), .clear(clear5), .bit_valid(bv5), .bit_in(bi5),
    .gen_start(gs5), .tx_ready(rdy5), .check(check5),
    .tx_valid(tx_valid5), .tx_bit(tx_bit5), .tx_done(tx_done5), .busy(busy5),
    .crc_ok(crc_ok5), .crc_err(crc_err5), .crc_value(crc_value5)
`ifdef USB_CRC_ERR_CNT_EN
    , .err_count(err_count5)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed16(input logic b);
    bv16 = 1'b1; bi16 = b; tick(); bv16 = 1'b0;
  endtask

  task automatic feed5(input logic b);
    bv5 = 1'b1; bi5 = b; tick(); bv5 = 1'b0;
  endtask

  task automatic chk_reset16(input string tag);
    chkv({tag, "_value"}, crc_value16, 16'hFFFF);
    chk1({tag, "_tx_valid"}, tx_valid16, 1'b0);
    chk1({tag, "_tx_bit"}, tx_bit16, 1'b0);
    chk1({tag, "_tx_done"}, tx_done16, 1'b0);
    chk1({tag, "_busy"}, busy16, 1'b0);
    chk1({tag, "_crc_err"}, crc_err16, 1'b0);
    chk1({tag, "_crc_ok"}, crc_ok16, 1'b0);
  endtask

  // CRC5 data stream (bit 10 first) and its inverted CRC (bit 4 first)
  logic [10:0] d5 = 11'b10100011001;
  logic [4:0]  t5 = 5'b11001;
  logic [4:0]  cap5;
  int k, dones;

  initial begin
    rst = 1'b1;
    {clear16, bv16, bi16, gs16, rdy16, check16} = '0;
    {clear5, bv5, bi5, gs5, rdy5, check5} = '0;
    cap5 = '0;
    tick();
    chk_reset16("reset");
    chkv("reset5_value", 16'(crc_value5), 16'h001F);
`ifdef USB_CRC_ERR_CNT_EN
    chkv("reset_err_count", 16'(err_count5), 16'h0000);
`endif
    rst = 1'b0;
    tick();

    // CRC16 over an empty packet: 16 zero bits out, then tx_done
    clear16 = 1'b1; tick(); clear16 = 1'b0;
    gs16 = 1'b1; rdy16 = 1'b1; tick(); gs16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk1("gen16_valid", tx_valid16, 1'b1);
      chk1("gen16_bit", tx_bit16, 1'b0);
      chk1("gen16_no_done", tx_done16, 1'b0);
      tick();
    end
    chk1("gen16_done", tx_done16, 1'b1);
    chk1("gen16_busy_low", busy16, 1'b0);
    chk1("gen16_valid_low", tx_valid16, 1'b0);
    tick();
    chk1("gen16_done_pulse", tx_done16, 1'b0);
    rdy16 = 1'b0;

    // CRC16 residual after 16 zero bits
    clear16 = 1'b1; tick(); clear16 = 1'b0;
    feed16(1'b0);
    chkv("abs16_first", crc_value16, 16'h7FFB);
    chk1("abs16_first_ok", crc_ok16, 1'b0);
    for (int i = 0; i < 15; i++) feed16(1'b0);
    chkv("abs16_residual", crc_value16, 16'h800D);
    chk1("abs16_ok", crc_ok16, 1'b1);
    check16 = 1'b1; tick(); check16 = 1'b0;
    chk1("abs16_no_err", crc_err16, 1'b0);

    // CRC5: data, last bit together with gen_start, stalled output
    clear5 = 1'b1; tick(); clear5 = 1'b0;
    for (int i = 10; i >= 1; i--) feed5(d5[i]);
    bv5 = 1'b1; bi5 = d5[0]; gs5 = 1'b1; tick();
    chkv("crc5_after_data", 16'(crc_value5), 16'h0006);
    chk1("crc5_busy", busy5, 1'b1);
    k = 0; dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 2) begin gs5 = 1'b0; bv5 = 1'b0; end
      rdy5 = (c % 3 == 0);
      if (tx_valid5) begin
        if (k < 5) chk1("crc5_tx_bit", tx_bit5, t5[4-k]);
        else       chk1("crc5_extra_valid", tx_valid5, 1'b0);
        if (rdy5 && k < 5) cap5[4-k] = tx_bit5;
        if (rdy5) k++;
      end
      if (tx_done5) dones++;
      tick();
    end
    rdy5 = 1'b0;
    chkv("crc5_bits_accepted", 16'(k), 16'd5);
    chkv("crc5_done_count", 16'(dones), 16'd1);
    chk1("crc5_idle", busy5, 1'b0);

    // Loop generated CRC back behind the same data
    clear5 = 1'b1; tick(); clear5 = 1'b0;
    for (int i = 10; i >= 0; i--) feed5(d5[i]);
    for (int j = 4; j >= 0; j--) feed5(cap5[j]);
    chkv("loop5_residual", 16'(crc_value5), 16'h000C);
    chk1("loop5_ok", crc_ok5, 1'b1);
    check5 = 1'b1; tick(); check5 = 1'b0;
    chk1("loop5_no_err", crc_err5, 1'b0);

    // Same with one data bit flipped
    clear5 = 1'b1; tick(); clear5 = 1'b0;
    feed5(~d5[10]);
    for (int i = 9; i >= 0; i--) feed5(d5[i]);
    for (int j = 4; j >= 0; j--) feed5(cap5[j]);
    chk1("flip5_not_ok", crc_ok5, 1'b0);
    check5 = 1'b1; tick(); check5 = 1'b0;
    chk1("flip5_err", crc_err5, 1'b1);
    tick();
    chk1("flip5_err_pulse", crc_err5, 1'b0);

    // clear during GEN with bit_valid high
    clear16 = 1'b1; tick(); clear16 = 1'b0;
    feed16(1'b1);
    chkv("abort16_pre", crc_value16, 16'hFFFE);
    gs16 = 1'b1; rdy16 = 1'b1; tick(); gs16 = 1'b0;
    tick(); tick(); tick();
    chkv("abort16_shifted", crc_value16, 16'hFFF7);
    chk1("abort16_in_gen", busy16, 1'b1);
    clear16 = 1'b1; bv16 = 1'b1; bi16 = 1'b1; tick();
    clear16 = 1'b0; bv16 = 1'b0;
    chk1("abort16_busy", busy16, 1'b0);
    chk1("abort16_valid", tx_valid16, 1'b0);
    chk1("abort16_tx_bit", tx_bit16, 1'b0);
    chkv("abort16_value", crc_value16, 16'hFFFF);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_done16) dones++;
      tick();
    end
    rdy16 = 1'b0;
    chkv("abort16_no_done", 16'(dones), 16'd0);

    // rst in ACCUM beats check and gen_start
    feed16(1'b1); feed16(1'b1);
    chkv("rst16_pre", crc_value16, 16'hFFFC);
    rst = 1'b1; check16 = 1'b1; gs16 = 1'b1; tick();
    rst = 1'b0; check16 = 1'b0; gs16 = 1'b0;
    chk_reset16("rst16");

`ifdef USB_CRC_ERR_CNT_EN
    for (int i = 0; i < 257; i++) begin
      check5 = 1'b1; tick(); check5 = 1'b0; tick();
    end
    chkv("errcnt_sat", 16'(err_count5), 16'd255);
    clear5 = 1'b1; tick(); clear5 = 1'b0;
    chkv("errcnt_clear", 16'(err_count5), 16'd255);
    rst = 1'b1; tick(); rst = 1'b0;
    chkv("errcnt_rst", 16'(err_count5), 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usb_crc_engine.md
# usb_crc_engine

Parametrised CRC engine for the USB bit-level datapath. One instance accumulates a CRC over a serial bit stream. In receive mode it checks the stream against the protocol residual; in transmit mode it shifts out the inverted CRC, MSB first, through a ready/valid handshake. The same RTL serves CRC5 (token packets) and CRC16 (data packets) by parameter, and sits between the bit-unstuffing/stuffing stage and the packet-level controller.

## Interface
- WIDTH, 16: CRC register width; legal range 2..32 (USB uses 5 and 16).
- POLY, 16'h8005: generator polynomial without the implicit x^WIDTH term (CRC5: 5'h05).
- RESIDUAL, 16'h800D: register value indicating a good packet after data+CRC are absorbed (CRC5: 5'h0C).
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  start of packet; reloads register to all ones.
- bit_valid  in  1  bit_in is absorbed this cycle.
- bit_in  in  1  serial data, LSB-of-byte first as on the wire.
- gen_start  in  1  pulse; begin shifting out the CRC.
- tx_ready  in  1  consumer accepts tx_bit this cycle.
- check  in  1  pulse at end of packet; samples crc_ok.
- tx_valid  out  1  tx_bit is valid.
- tx_bit  out  1  current CRC output bit.
- tx_done  out  1  one-cycle pulse after the last CRC bit is accepted.
- busy  out  1  high while in GEN.
- crc_ok  out  1  register equals RESIDUAL and state is ACCUM.
- crc_err  out  1  registered one-cycle pulse: check was high while crc_ok was low.
- crc_value  out  WIDTH  live register contents.

## Operation
- Register q, reset/clear value all ones.
- Absorb step, taken when bit_valid is high in ACCUM: fb = bit_in ^ q[WIDTH-1]; q <= {q[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
- States:
  - ACCUM (reset state): absorbs bits. gen_start moves the block to GEN and loads cnt = WIDTH-1.
  - GEN: tx_valid = 1 and tx_bit = ~q[WIDTH-1]. On each tx_ready: q <= {q[WIDTH-2:0],1'b1} and cnt decrements.
  - On tx_ready with cnt == 0: q <= all ones, tx_done pulses next cycle, and the block returns to ACCUM.
- Priority order: rst > clear > state logic.
  - clear in GEN aborts the generation: ACCUM, q all ones, tx_valid low next cycle, no tx_done.
- Simultaneous events:
  - bit_valid and gen_start together in ACCUM: the bit is absorbed first, GEN starts next cycle, and the emitted CRC includes that bit.
  - In GEN, bit_valid and gen_start are ignored.
- crc_ok is combinational from q and state; it is forced 0 in GEN.
- cnt width is $clog2(WIDTH).

## Timing
- Reset values: q all ones, state ACCUM, tx_valid 0, tx_bit 0 (gated by tx_valid), tx_done 0, busy 0, crc_err 0, crc_ok 0 (the legal RESIDUAL is never all ones).
- Absorb latency: one cycle. crc_ok reflects a bit absorbed at edge N in the cycle after edge N.
- gen_start at edge N: tx_valid high from N+1. With tx_ready held high, WIDTH bits are emitted on consecutive cycles, and tx_done is high in the cycle after the last accepted bit.
- tx_bit is stable while tx_valid is high and tx_ready is low.
- crc_err is registered one cycle after check.

## Configuration
- USB_CRC_ERR_CNT_EN defined:
  - Adds output err_count [7:0], reset 0.
  - err_count increments on every crc_err pulse and saturates at 255.
  - Only rst clears it; clear does not.
- USB_CRC_ERR_CNT_EN undefined: the err_count port and its logic are absent; all other behaviour is identical.

## Structure
- usb_crc_pkg holds:
  - the state enum typedef crc_state_t {ACCUM, GEN};
  - constants CRC5_POLY 5'h05, CRC5_RESIDUAL 5'h0C, CRC16_POLY 16'h8005, CRC16_RESIDUAL 16'h800D.
- Sub-module usb_crc_step is the purely combinational one-bit absorb function, parametrised by WIDTH/POLY; it is reused by the bench model.

## Test plan
- CRC16, clear, then gen_start with no data, tx_ready=1 -> 16 tx_bit zeros, tx_done on cycle 17, busy low afterwards.
- CRC16, clear, then absorb 16 zero bits -> crc_value 16'h800D, crc_ok=1; check pulse -> crc_err stays 0.
- CRC5 (WIDTH 5, POLY 5'h05, RESIDUAL 5'h0C), 11 random bits, then generated CRC looped back into bit_in -> crc_ok=1. Flip one data bit -> crc_ok=0, check gives crc_err pulse one cycle later.
- tx_ready toggled 1,0,0,1,... during GEN -> tx_bit held while stalled, exactly WIDTH bits accepted, a single tx_done.
- clear asserted mid-GEN with bit_valid high -> ACCUM, q=all ones, no tx_done. rst mid-ACCUM -> all outputs at reset values next cycle.
- With USB_CRC_ERR_CNT_EN: 257 failing checks -> err_count 255. clear leaves it unchanged; rst zeroes it.
